clock_scaler_bank: RTL and testbench
====================================

Name: clock_scaler_bank

Overview:
- Bank of NUM_CH independent clock dividers.
- Each channel's divisor is programmable at run time; each channel has its own enable.
- Each channel runs in one of two modes: 50%-duty square wave (toggle) or single-cycle tick strobe.
- Feeds blink-rate and sequencing timebases to the lighting FSMs from the single board clock, replacing one fixed divider per rate.

Parameters:
- NUM_CH, 4, number of divider channels (1..16).
- CNT_W, 27, counter and divisor width in bits.
- DEFAULT_DIV, 50000000, divisor loaded into every channel at reset (must be < 2**CNT_W).
- SEL_W, $clog2(NUM_CH) (minimum 1), width of the channel-select field.

Ports:
- clk  input  1  board clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0); deassertion is synchronous to clk by the board.
- enable  input  NUM_CH  per-channel run enable.
- mode  input  NUM_CH  per-channel mode: 0 = toggle (square wave), 1 = tick (pulse).
- div_wr  input  1  single-cycle divisor write strobe.
- div_sel  input  SEL_W  target channel of the write.
- div_val  input  CNT_W  new divisor value.
- div_ack  output  1  one-cycle acknowledge, asserted the cycle after div_wr.
- div_err  output  1  valid with div_ack; 1 = div_sel was out of range and the write was dropped.
- tick  output  NUM_CH  one-cycle strobe at each terminal count.
- scaled_clk  output  NUM_CH  divided output; content depends on mode.

Behaviour:
- Reset (reset=0, asynchronous):
  - All counters = 0.
  - Active and shadow divisor = DEFAULT_DIV.
  - pending flags = 0; tick = 0; scaled_clk = 0; div_ack = 0; div_err = 0.
- Effective divisor D = max(active_div, 1); a div value of 0 is treated as 1.
- Enabled channel, per clk:
  - If cnt == D-1: cnt <= 0 and tick = 1 for that cycle (registered output).
  - Otherwise cnt <= cnt+1.
  - Resulting tick period is exactly D clk cycles.
- Toggle mode (mode=0): scaled_clk toggles on each terminal count, giving period 2*D cycles and 50% duty. With D=1 the output is clk/2.
- Tick mode (mode=1):
  - scaled_clk equals tick.
  - The toggle flop is cleared to 0 while mode=1, so a return to toggle mode always starts low.
- Disabled channel (enable=0):
  - cnt held at 0; tick = 0; scaled_clk = 0 (toggle flop cleared).
  - Re-enable: the first tick occurs D cycles after the first enabled edge.
- Divisor write (div_wr=1, div_sel < NUM_CH):
  - div_val is captured into that channel's shadow register and its pending flag is set.
  - Next cycle: div_ack = 1, div_err = 0.
- Out-of-range write (div_sel >= NUM_CH):
  - No state changes.
  - Next cycle: div_ack = 1, div_err = 1.
- Applying a pending divisor:
  - Enabled channel: at its next terminal count, active_div <= shadow and pending is cleared. The current period always completes with the old divisor, so there are no runt periods.
  - Disabled channel: the shadow is applied on the cycle after the write, and cnt stays 0.
- Write on the same cycle as a terminal count: the terminal count uses the old active divisor; the new value becomes pending and applies at the following terminal count.
- Second write to a channel that already has a pending value: the shadow is overwritten and the last write wins.
- div_wr held high for multiple cycles: each cycle counts as a separate write, and div_ack stays high for the same number of cycles.
- Mode change mid-period: takes effect on the next clk and does not reset cnt.
- Reset asserted mid-operation: every output goes to 0 immediately, without waiting for a clock edge, and all pending writes are lost.

Decomposition:
- Package clock_scaler_pkg:
  - MODE_TOGGLE = 1'b0, MODE_TICK = 1'b1.
  - Default CNT_W and DEFAULT_DIV constants.
- Sub-module clock_scaler_ch: one channel (counter, active/shadow divisor, pending flag, toggle flop, tick).
- clock_scaler_bank:
  - Instantiates clock_scaler_ch in a generate loop.
  - Owns write decode and the div_ack/div_err register.

Test Plan:
- Bench uses DEFAULT_DIV=5, NUM_CH=4.
1. Reset release, all enable=1, mode=0 -> tick on every channel every 5 cycles; scaled_clk period 10 cycles at 50% duty; all outputs 0 while reset=0.
2. Write div_sel=2, div_val=3 mid-period on ch2 -> div_ack=1/div_err=0 the next cycle; ch2 completes its current 5-cycle period, then ticks every 3 cycles; other channels unchanged.
3. Write div_sel=1, div_val=0 and separately div_sel=1, div_val=1 -> ch1 ticks every cycle in both cases; with mode=0, scaled_clk=clk/2.
4. Write div_sel=3 on the exact terminal-count cycle of ch3, then a second write before the next terminal count -> the old period completes, and only the second value is applied at the following terminal count.
5. On ch0: drop enable for 7 cycles, then toggle mode 0->1 -> outputs 0 while disabled; first tick 5 cycles after re-enable; in tick mode scaled_clk equals tick (1-cycle pulses).
6. Write with div_sel=4 (NUM_CH=4), and in another case assert reset=0 mid-count with a write pending -> div_ack=1, div_err=1, no channel changes; outputs go to 0 asynchronously, and after release every channel runs at divisor 5.

Source files
------------

// File: rtl/clock_scaler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_scaler_pkg
// Brief    : Shared mode encodings and default sizing for the clock scaler bank.
// Revision : 1.0
// ============================================================================
package clock_scaler_pkg;

    localparam logic        MODE_TOGGLE   = 1'b0;
    localparam logic        MODE_TICK     = 1'b1;

    localparam int          C_CNT_W       = 27;
    localparam int unsigned C_DEFAULT_DIV = 50_000_000;

endpackage : clock_scaler_pkg
`default_nettype wire

// File: rtl/clock_scaler_ch.sv
`default_nettype none
// ============================================================================
// Module   : clock_scaler_ch
// Brief    : One divider channel with shadowed divisor, tick strobe and toggle output.
// Revision : 1.0
// ============================================================================
module clock_scaler_ch
    import clock_scaler_pkg::*;
#(
    parameter int          CNT_W       = C_CNT_W,
    parameter int unsigned DEFAULT_DIV = C_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_mode,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_val,
    output logic             o_tick,
    output logic             o_scaled_clk
);

    localparam logic [CNT_W-1:0] C_RST_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_tog;
    logic             r_tick;
    logic             r_sclk;

    logic [CNT_W-1:0] w_div_eff;
    logic             w_tc;
    logic             w_apply;
    logic             w_tog_next;
    logic             w_sclk_next;

    // A zero divisor behaves as one so the channel never stalls.
    assign w_div_eff = (r_active == '0) ? C_ONE : r_active;
    assign w_tc      = i_enable && (r_cnt == (w_div_eff - C_ONE));
    // Disabled channels take the shadow immediately; running ones wait for the period end.
    assign w_apply   = r_pending && (!i_enable || w_tc);

    always_comb begin
        w_tog_next = r_tog;
        if (!i_enable || (i_mode == MODE_TICK)) begin
            w_tog_next = 1'b0;
        end else if (w_tc) begin
            w_tog_next = ~r_tog;
        end
        w_sclk_next = (i_mode == MODE_TOGGLE) ? w_tog_next : w_tc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_active  <= C_RST_DIV;
            r_shadow  <= C_RST_DIV;
            r_pending <= 1'b0;
            r_tog     <= 1'b0;
            r_tick    <= 1'b0;
            r_sclk    <= 1'b0;
        end else begin
            r_cnt  <= (!i_enable || w_tc) ? '0 : r_cnt + C_ONE;
            r_tick <= w_tc;
            r_tog  <= w_tog_next;
            r_sclk <= w_sclk_next;
            if (w_apply) begin
                r_active <= r_shadow;
            end
            // A new write always leaves a value pending, even on the cycle an older one lands.
            if (i_wr) begin
                r_shadow  <= i_wr_val;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_tick       = r_tick;
    assign o_scaled_clk = r_sclk;

endmodule : clock_scaler_ch
`default_nettype wire

// File: rtl/clock_scaler_bank.sv
`default_nettype none
// ============================================================================
// Module   : clock_scaler_bank
// Brief    : NUM_CH programmable clock dividers with a shared divisor write port.
// Revision : 1.0
// ============================================================================
module clock_scaler_bank
    import clock_scaler_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = C_CNT_W,
    parameter int unsigned DEFAULT_DIV = C_DEFAULT_DIV,
    parameter int          SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] mode,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_val,
    output logic              div_ack,
    output logic              div_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] scaled_clk
);

    logic [31:0]       w_sel_ext;
    logic              w_in_range;
    logic [NUM_CH-1:0] w_wr;
    logic              r_ack;
    logic              r_err;

    assign w_sel_ext  = 32'(div_sel);
    assign w_in_range = (w_sel_ext < 32'(NUM_CH));

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_wr[gi] = div_wr && w_in_range && (w_sel_ext == 32'(gi));

            clock_scaler_ch #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk          (clk),
                .reset        (reset),
                .i_enable     (enable[gi]),
                .i_mode       (mode[gi]),
                .i_wr         (w_wr[gi]),
                .i_wr_val     (div_val),
                .o_tick       (tick[gi]),
                .o_scaled_clk (scaled_clk[gi])
            );
        end
    endgenerate

    // Every write cycle is acknowledged; out-of-range selects are flagged and dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= div_wr;
            r_err <= div_wr && !w_in_range;
        end
    end

    assign div_ack = r_ack;
    assign div_err = r_err;

endmodule : clock_scaler_bank
`default_nettype wire

// File: tb/tb_clock_scaler_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_scaler_bank
// Brief    : Directed bench for clock_scaler_bank with a countdown reference model.
// Revision : 1.0
// ============================================================================
module tb_clock_scaler_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int SEL_W  = 3;
    localparam int DEF    = 5;

    typedef struct packed {
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] sclk;
        logic              ack;
        logic              err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NUM_CH-1:0] enable = '0;
    logic [NUM_CH-1:0] mode = '0;
    logic              div_wr = 1'b0;
    logic [SEL_W-1:0]  div_sel = '0;
    logic [CNT_W-1:0]  div_val = '0;
    logic              div_ack;
    logic              div_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] scaled_clk;

    int checks = 0;
    int errors = 0;

    exp_t q[$];

    // Reference state: cycles remaining until the next tick, rather than an up-counter.
    int               m_left[NUM_CH];
    logic [CNT_W-1:0] m_act[NUM_CH];
    logic [CNT_W-1:0] m_shd[NUM_CH];
    bit               m_pend[NUM_CH];
    bit               m_tog[NUM_CH];

    clock_scaler_bank #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF),
        .SEL_W       (SEL_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .div_wr     (div_wr),
        .div_sel    (div_sel),
        .div_val    (div_val),
        .div_ack    (div_ack),
        .div_err    (div_err),
        .tick       (tick),
        .scaled_clk (scaled_clk)
    );

    always #5 clk = ~clk;

    function automatic int eff(input logic [CNT_W-1:0] d);
        return (d == '0) ? 1 : int'(d);
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_left[c] = DEF;
            m_act[c]  = CNT_W'(DEF);
            m_shd[c]  = CNT_W'(DEF);
            m_pend[c] = 1'b0;
            m_tog[c]  = 1'b0;
        end
    endtask

    task automatic model_edge(output exp_t e);
        e = '0;
        if (!reset) begin
            model_reset();
            return;
        end
        e.ack = div_wr;
        e.err = div_wr && (int'(div_sel) >= NUM_CH);
        for (int c = 0; c < NUM_CH; c++) begin
            if (!enable[c]) begin
                if (m_pend[c]) begin
                    m_act[c]  = m_shd[c];
                    m_pend[c] = 1'b0;
                end
                m_left[c] = eff(m_act[c]);
                m_tog[c]  = 1'b0;
            end else begin
                if (m_left[c] == 1) begin
                    e.tick[c] = 1'b1;
                    if (m_pend[c]) begin
                        m_act[c]  = m_shd[c];
                        m_pend[c] = 1'b0;
                    end
                    m_left[c] = eff(m_act[c]);
                    m_tog[c]  = ~m_tog[c];
                end else begin
                    m_left[c] = m_left[c] - 1;
                end
                if (mode[c]) m_tog[c] = 1'b0;
            end
            e.sclk[c] = mode[c] ? e.tick[c] : (enable[c] & m_tog[c]);
            if (div_wr && (int'(div_sel) == c)) begin
                m_shd[c]  = div_val;
                m_pend[c] = 1'b1;
            end
        end
    endtask

    // Expected result is queued before the edge and retired at the following falling edge.
    task automatic step();
        exp_t e;
        exp_t o;
        model_edge(e);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        o = q.pop_front();
        check("tick", tick, o.tick);
        check("scaled_clk", scaled_clk, o.sclk);
        check("div_ack", {3'b0, div_ack}, {3'b0, o.ack});
        check("div_err", {3'b0, div_err}, {3'b0, o.err});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int sel, input int val);
        div_wr  = 1'b1;
        div_sel = SEL_W'(sel);
        div_val = CNT_W'(val);
        step();
        div_wr  = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset held: everything low.
        run(3);
        check("rst_tick", tick, 4'h0);
        check("rst_sclk", scaled_clk, 4'h0);

        // Release with all channels toggling at the default divisor.
        reset  = 1'b1;
        enable = 4'hF;
        mode   = 4'h0;
        run(4);
        check("pre_first_tick", tick, 4'h0);
        step();
        check("first_tick", tick, 4'hF);
        check("first_sclk", scaled_clk, 4'hF);
        run(12);

        // Mid-period divisor change on ch2.
        run(2);
        wr(2, 3);
        check("ack_ch2", {3'b0, div_ack}, 4'h1);
        check("err_ch2", {3'b0, div_err}, 4'h0);
        run(15);

        // ch1 with divisor 0 then 1: tick every cycle, scaled_clk at clk/2.
        wr(1, 0);
        run(10);
        wr(1, 1);
        run(8);

        // Write ch3 on its terminal-count edge, then overwrite before the next one.
        for (int k = 0; k < 20 && m_left[3] != 1; k++) step();
        wr(3, 7);
        step();
        wr(3, 4);
        run(16);

        // ch0 disable, re-enable, tick mode, back to toggle.
        enable[0] = 1'b0;
        run(7);
        enable[0] = 1'b1;
        run(8);
        mode[0] = 1'b1;
        run(12);
        mode[0] = 1'b0;
        run(12);

        // Held write strobe: two consecutive writes, two acks.
        div_wr = 1'b1; div_sel = 3'd2; div_val = 8'd4;
        step();
        div_val = 8'd2;
        step();
        div_wr = 1'b0;
        run(10);

        // Out-of-range select.
        wr(4, 9);
        check("ack_oor", {3'b0, div_ack}, 4'h1);
        check("err_oor", {3'b0, div_err}, 4'h1);
        run(12);

        // Asynchronous reset with a write pending.
        wr(0, 11);
        run(2);
        reset = 1'b0;
        #1;
        check("async_tick", tick, 4'h0);
        check("async_sclk", scaled_clk, 4'h0);
        check("async_ack", {2'b0, div_ack, div_err}, 4'h0);
        model_reset();
        run(2);
        reset = 1'b1;
        run(25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clock_scaler_bank
`default_nettype wire
